// File: rtl/wb_write_arbiter_if.sv
// ----------------------------------------------------------------------------
// wb_write_arbiter_if
// Bundle of the pipeline writeback, MUL/DIV result handshake and REG_FILE
// write-port signals for wb_write_arbiter.
//   slave  : the arbiter side (consumes PIPE_*/MD_*, drives MD_READY,
//            WRITE/ADDRW/IN, BUSY_MASK, COUNT)
//   master : the producer/observer side (drives PIPE_*/MD_*)
// Parameters:
//   XLEN   data width
//   DEPTH  MUL/DIV holding-FIFO entries (COUNT is clog2(DEPTH)+1 bits)
// ----------------------------------------------------------------------------
interface wb_write_arbiter_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
);
    logic                     PIPE_VALID;
    logic [4:0]               PIPE_RD;
    logic [XLEN-1:0]          PIPE_DATA;
    logic                     MD_VALID;
    logic                     MD_READY;
    logic [4:0]               MD_RD;
    logic [XLEN-1:0]          MD_DATA;
    logic                     WRITE;
    logic [4:0]               ADDRW;
    logic [XLEN-1:0]          IN;
    logic [31:0]              BUSY_MASK;
    logic [$clog2(DEPTH):0]   COUNT;

    modport slave (
        input  PIPE_VALID, PIPE_RD, PIPE_DATA,
        input  MD_VALID, MD_RD, MD_DATA,
        output MD_READY,
        output WRITE, ADDRW, IN,
        output BUSY_MASK, COUNT
    );

    modport master (
        output PIPE_VALID, PIPE_RD, PIPE_DATA,
        output MD_VALID, MD_RD, MD_DATA,
        input  MD_READY,
        input  WRITE, ADDRW, IN,
        input  BUSY_MASK, COUNT
    );
endinterface

// File: rtl/wb_write_arbiter.sv
// ----------------------------------------------------------------------------
// wb_write_arbiter
// Merges single-cycle pipeline writebacks and multi-cycle MUL/DIV results into
// one registered REG_FILE write stream. Pipeline writes always win and never
// stall; colliding MUL/DIV results wait in a small in-order FIFO and drain on
// cycles the pipeline leaves idle. A pipeline write is treated as younger than
// any queued or same-cycle MUL/DIV result to the same register, so those older
// results are discarded rather than written.
//
// Ports:
//   CLK          clock, all state on posedge
//   RESET        synchronous, active-low reset
//   bus (slave)  PIPE_VALID/PIPE_RD/PIPE_DATA  pipeline writeback
//                MD_VALID/MD_READY/MD_RD/MD_DATA MUL/DIV result handshake
//                WRITE/ADDRW/IN                 registered REG_FILE write
//                BUSY_MASK                      bit r set while a live entry
//                                               targets r
//                COUNT                          occupied FIFO slots
// Optional (macro WB_BYPASS_EN):
//   RS1/RS2, RF_OUT1/RF_OUT2 in; FWD1/FWD2 out -- forwards the write in flight
//   over the REG_FILE read data to cover the write-then-read window.
// ----------------------------------------------------------------------------
module wb_write_arbiter #(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32
) (
    input  logic                CLK,
    input  logic                RESET,
    wb_write_arbiter_if.slave   bus
`ifdef WB_BYPASS_EN
    ,
    input  logic [4:0]          RS1,
    input  logic [4:0]          RS2,
    input  logic [XLEN-1:0]     RF_OUT1,
    input  logic [XLEN-1:0]     RF_OUT2,
    output logic [XLEN-1:0]     FWD1,
    output logic [XLEN-1:0]     FWD2
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // FIFO storage; a slot whose vld bit is clear is either free or killed.
    logic [XLEN-1:0]  data_mem [DEPTH];
    logic [4:0]       rd_mem   [DEPTH];
    logic [DEPTH-1:0] vld_reg, vld_next;
    logic [PW-1:0]    head_reg, head_next, tail_reg, tail_next;
    logic [CW-1:0]    count_reg, count_next;

    logic             write_reg, write_next;
    logic [4:0]       addrw_reg, addrw_next;
    logic [XLEN-1:0]  in_reg, in_next;

    logic             pipe_hit, md_acc, md_keep, head_found, push;
    logic [PW-1:0]    sel_idx;
    logic [CW-1:0]    npop, npop_eff;
    logic [PW-1:0]    scan_idx  [DEPTH];
    logic [31:0]      slot_mask [DEPTH];
    logic [31:0]      busy_mask;

    assign bus.MD_READY = RESET && (count_reg < CW'(DEPTH));

    assign pipe_hit = bus.PIPE_VALID && (bus.PIPE_RD != 5'd0);
    assign md_acc   = bus.MD_VALID && bus.MD_READY;
    // An accepted result for x0, or one overtaken by a same-cycle pipeline
    // write to the same register, completes its handshake and is dropped.
    assign md_keep  = md_acc && (bus.MD_RD != 5'd0) &&
                      !(pipe_hit && (bus.MD_RD == bus.PIPE_RD));

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            assign scan_idx[gi]  = head_reg + PW'(gi);
            assign slot_mask[gi] = vld_reg[gi] ? (32'd1 << rd_mem[gi]) : 32'd0;
        end
    endgenerate

    // Find the oldest live entry. Killed slots ahead of it are popped together
    // with it; if nothing live is queued, every occupied (dead) slot drains.
    always_comb begin
        head_found = 1'b0;
        sel_idx    = head_reg;
        npop       = count_reg;
        for (int k = 0; k < DEPTH; k++) begin
            if (!head_found && (CW'(k) < count_reg) && vld_reg[scan_idx[k]]) begin
                head_found = 1'b1;
                sel_idx    = scan_idx[k];
                npop       = CW'(k + 1);
            end
        end
    end

    always_comb begin
        write_next = 1'b0;
        addrw_next = 5'd0;
        in_next    = '0;
        npop_eff   = '0;
        push       = 1'b0;
        vld_next   = vld_reg;

        if (pipe_hit) begin
            write_next = 1'b1;
            addrw_next = bus.PIPE_RD;
            in_next    = bus.PIPE_DATA;
            // Older queued results to the same register must never land.
            for (int i = 0; i < DEPTH; i++) begin
                if (rd_mem[i] == bus.PIPE_RD) begin
                    vld_next[i] = 1'b0;
                end
            end
            push = md_keep;
        end else if (head_found) begin
            write_next        = 1'b1;
            addrw_next        = rd_mem[sel_idx];
            in_next           = data_mem[sel_idx];
            npop_eff          = npop;
            vld_next[sel_idx] = 1'b0;
            push              = md_keep;
        end else begin
            npop_eff = npop;
            if (md_keep) begin
                write_next = 1'b1;
                addrw_next = bus.MD_RD;
                in_next    = bus.MD_DATA;
            end
        end

        // MD_READY guarantees the tail slot is free whenever push is set.
        if (push) begin
            vld_next[tail_reg] = 1'b1;
        end

        count_next = count_reg - npop_eff + CW'(push);
        head_next  = head_reg + npop_eff[PW-1:0];
        tail_next  = tail_reg + PW'(push);
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            vld_reg   <= '0;
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
            write_reg <= 1'b0;
            addrw_reg <= 5'd0;
            in_reg    <= '0;
        end else begin
            vld_reg   <= vld_next;
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
            write_reg <= write_next;
            addrw_reg <= addrw_next;
            in_reg    <= in_next;
        end
    end

    // Payload storage needs no reset: slots are only read while vld is set.
    always_ff @(posedge CLK) begin
        if (push) begin
            data_mem[tail_reg] <= bus.MD_DATA;
            rd_mem[tail_reg]   <= bus.MD_RD;
        end
    end

    always_comb begin
        busy_mask = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            busy_mask = busy_mask | slot_mask[i];
        end
    end

    assign bus.WRITE     = write_reg;
    assign bus.ADDRW     = addrw_reg;
    assign bus.IN        = in_reg;
    assign bus.COUNT     = count_reg;
    assign bus.BUSY_MASK = busy_mask;

`ifdef WB_BYPASS_EN
    assign FWD1 = (write_reg && (addrw_reg == RS1) && (RS1 != 5'd0)) ? in_reg : RF_OUT1;
    assign FWD2 = (write_reg && (addrw_reg == RS2) && (RS2 != 5'd0)) ? in_reg : RF_OUT2;
`endif

endmodule

// File: tb/tb_wb_write_arbiter.sv
// ----------------------------------------------------------------------------
// tb_wb_write_arbiter
// Directed, table-driven bench for wb_write_arbiter (DEPTH=2, XLEN=32).
// Each table row is one clock cycle: inputs driven before the edge, expected
// registered outputs and queue state checked 1 time unit after it.
// With WB_BYPASS_EN defined the forwarding outputs are exercised as well.
// ----------------------------------------------------------------------------
module tb_wb_write_arbiter;
    localparam int DEPTH = 2;
    localparam int XLEN  = 32;
    localparam int NV    = 22;

    logic CLK;
    logic RESET;

    wb_write_arbiter_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

`ifdef WB_BYPASS_EN
    logic [4:0]      RS1, RS2;
    logic [XLEN-1:0] RF_OUT1, RF_OUT2, FWD1, FWD2;
`endif

    wb_write_arbiter #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .bus     (bus.slave)
`ifdef WB_BYPASS_EN
        ,
        .RS1     (RS1),
        .RS2     (RS2),
        .RF_OUT1 (RF_OUT1),
        .RF_OUT2 (RF_OUT2),
        .FWD1    (FWD1),
        .FWD2    (FWD2)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        pv;
        logic [4:0]  prd;
        logic [31:0] pdat;
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] mdat;
        logic        ewr;
        logic [4:0]  ead;
        logic [31:0] edat;
        int          ecnt;
        logic        erdy;
        logic [31:0] ebusy;
    } vec_t;

    vec_t tbl [NV];
    int   n_vec  = 0;
    int   n_miss = 0;

    function automatic vec_t mk(input logic pv, input logic [4:0] prd, input logic [31:0] pdat,
                                input logic mv, input logic [4:0] mrd, input logic [31:0] mdat,
                                input logic ewr, input logic [4:0] ead, input logic [31:0] edat,
                                input int ecnt, input logic erdy, input logic [31:0] ebusy);
        vec_t v;
        v.pv = pv;   v.prd = prd; v.pdat = pdat;
        v.mv = mv;   v.mrd = mrd; v.mdat = mdat;
        v.ewr = ewr; v.ead = ead; v.edat = edat;
        v.ecnt = ecnt; v.erdy = erdy; v.ebusy = ebusy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic pv, input logic [4:0] prd, input logic [31:0] pdat,
                         input logic mv, input logic [4:0] mrd, input logic [31:0] mdat);
        bus.PIPE_VALID = pv;
        bus.PIPE_RD    = prd;
        bus.PIPE_DATA  = pdat;
        bus.MD_VALID   = mv;
        bus.MD_RD      = mrd;
        bus.MD_DATA    = mdat;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic show(input string tag);
        $display("%s: write=%0b addrw=%0d in=0x%08h count=%0d md_ready=%0b busy=0x%08h",
                 tag, bus.WRITE, bus.ADDRW, bus.IN, bus.COUNT, bus.MD_READY, bus.BUSY_MASK);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Test sequence: one row per cycle, state carries from row to row.
        //            pipe            md               expected write      cnt rdy busy
        tbl[0]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0,      1, 5, 32'hDEADBEEF, 0, 1, 32'h0);
        tbl[1]  = mk(0, 0, 0,            0, 0, 0,      0, 0, 0,            0, 1, 32'h0);
        // collision: pipe wins, MD queued then drained
        tbl[2]  = mk(1, 3, 32'h11,       1, 7, 32'h22, 1, 3, 32'h11,       1, 1, 32'h80);
        tbl[3]  = mk(0, 0, 0,            0, 0, 0,      1, 7, 32'h22,       0, 1, 32'h0);
        // full: pipe busy, MD offers three results, FIFO wraps
        tbl[4]  = mk(1, 1, 32'hA1,       1, 10, 32'hC0, 1, 1, 32'hA1,      1, 1, 32'h400);
        tbl[5]  = mk(1, 2, 32'hA2,       1, 11, 32'hC1, 1, 2, 32'hA2,      2, 0, 32'hC00);
        tbl[6]  = mk(1, 3, 32'hA3,       1, 12, 32'hC2, 1, 3, 32'hA3,      2, 0, 32'hC00);
        tbl[7]  = mk(0, 0, 0,            1, 12, 32'hC2, 1, 10, 32'hC0,     1, 1, 32'h800);
        tbl[8]  = mk(0, 0, 0,            1, 12, 32'hC2, 1, 11, 32'hC1,     1, 1, 32'h1000);
        tbl[9]  = mk(0, 0, 0,            0, 0, 0,      1, 12, 32'hC2,      0, 1, 32'h0);
        // WAW: queued MD x9 killed by younger pipe x9, dead slot drains silently
        tbl[10] = mk(1, 6, 32'h66,       1, 9, 32'hAA, 1, 6, 32'h66,       1, 1, 32'h200);
        tbl[11] = mk(1, 9, 32'hBB,       0, 0, 0,      1, 9, 32'hBB,       1, 1, 32'h0);
        tbl[12] = mk(0, 0, 0,            0, 0, 0,      0, 0, 0,            0, 1, 32'h0);
        // WAW same cycle: MD dropped after handshake
        tbl[13] = mk(1, 9, 32'hBC,       1, 9, 32'hCC, 1, 9, 32'hBC,       0, 1, 32'h0);
        tbl[14] = mk(0, 0, 0,            0, 0, 0,      0, 0, 0,            0, 1, 32'h0);
        // x0 from both sources: nothing written, nothing queued
        tbl[15] = mk(1, 0, 32'h55,       1, 0, 32'h66, 0, 0, 0,            0, 1, 32'h0);
        tbl[16] = mk(0, 0, 0,            0, 0, 0,      0, 0, 0,            0, 1, 32'h0);
        // empty FIFO: MD issued directly
        tbl[17] = mk(0, 0, 0,            1, 8, 32'h77, 1, 8, 32'h77,       0, 1, 32'h0);
        // killed head skipped, next live entry issued in the same cycle
        tbl[18] = mk(1, 13, 32'hD1,      1, 14, 32'hE1, 1, 13, 32'hD1,     1, 1, 32'h4000);
        tbl[19] = mk(1, 15, 32'hD2,      1, 16, 32'hE2, 1, 15, 32'hD2,     2, 0, 32'h14000);
        tbl[20] = mk(1, 14, 32'hD3,      0, 0, 0,      1, 14, 32'hD3,      2, 0, 32'h10000);
        tbl[21] = mk(0, 0, 0,            0, 0, 0,      1, 16, 32'hE2,      0, 1, 32'h0);

`ifdef WB_BYPASS_EN
        RS1 = 5'd0; RS2 = 5'd0; RF_OUT1 = 32'h0; RF_OUT2 = 32'h0;
`endif

        // Reset held two cycles with a live pipeline write on the inputs.
        RESET = 1'b0;
        drive(1, 5, 32'h12345678, 0, 0, 0);
        step();
        step();
        n_vec++;
        show("reset");
        chk("reset.write", 32'(bus.WRITE), 32'h0);
        chk("reset.addrw", 32'(bus.ADDRW), 32'h0);
        chk("reset.in", bus.IN, 32'h0);
        chk("reset.count", 32'(bus.COUNT), 32'h0);
        chk("reset.md_ready", 32'(bus.MD_READY), 32'h0);
        chk("reset.busy", bus.BUSY_MASK, 32'h0);

        RESET = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        #1;
        n_vec++;
        show("release");
        chk("release.md_ready", 32'(bus.MD_READY), 32'h1);

        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].pv, tbl[i].prd, tbl[i].pdat, tbl[i].mv, tbl[i].mrd, tbl[i].mdat);
            step();
            n_vec++;
            show($sformatf("vec %0d", i));
            chk($sformatf("vec%0d.write", i), 32'(bus.WRITE), 32'(tbl[i].ewr));
            if (tbl[i].ewr) begin
                chk($sformatf("vec%0d.addrw", i), 32'(bus.ADDRW), 32'(tbl[i].ead));
                chk($sformatf("vec%0d.in", i), bus.IN, tbl[i].edat);
            end
            chk($sformatf("vec%0d.count", i), 32'(bus.COUNT), 32'(tbl[i].ecnt));
            chk($sformatf("vec%0d.md_ready", i), 32'(bus.MD_READY), 32'(tbl[i].erdy));
            chk($sformatf("vec%0d.busy", i), bus.BUSY_MASK, tbl[i].ebusy);
        end

        // Reset mid-operation discards a queued result.
        drive(1, 20, 32'hF0, 1, 21, 32'hF1);
        step();
        n_vec++;
        show("midrst.fill");
        chk("midrst.fill.count", 32'(bus.COUNT), 32'h1);
        chk("midrst.fill.busy", bus.BUSY_MASK, 32'h0020_0000);
        RESET = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        step();
        n_vec++;
        show("midrst.reset");
        chk("midrst.reset.write", 32'(bus.WRITE), 32'h0);
        chk("midrst.reset.count", 32'(bus.COUNT), 32'h0);
        chk("midrst.reset.busy", bus.BUSY_MASK, 32'h0);
        chk("midrst.reset.md_ready", 32'(bus.MD_READY), 32'h0);
        RESET = 1'b1;
        step();
        n_vec++;
        show("midrst.after");
        chk("midrst.after.write", 32'(bus.WRITE), 32'h0);
        chk("midrst.after.md_ready", 32'(bus.MD_READY), 32'h1);

`ifdef WB_BYPASS_EN
        // Forwarding of the write in flight: x4=0x55 with RS1=4.
        drive(1, 4, 32'h55, 0, 0, 0);
        RS1 = 5'd4; RS2 = 5'd3; RF_OUT1 = 32'h1234; RF_OUT2 = 32'h5678;
        step();
        n_vec++;
        show("bypass");
        chk("bypass.write", 32'(bus.WRITE), 32'h1);
        chk("bypass.fwd1", FWD1, 32'h55);
        chk("bypass.fwd2", FWD2, 32'h5678);
        drive(0, 0, 0, 0, 0, 0);
        step();
        n_vec++;
        show("bypass.idle");
        chk("bypass.idle.fwd1", FWD1, 32'h1234);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
